// File: rtl/wb_gpio_ctrl_pkg.sv
// Shared definitions for the Wishbone GPIO controller: register indices,
// decoded register enum and the byte-lane mask helper.
package wb_gpio_ctrl_pkg;

  localparam logic [2:0] REG_IN      = 3'd0;
  localparam logic [2:0] REG_OUT     = 3'd1;
  localparam logic [2:0] REG_OE      = 3'd2;
  localparam logic [2:0] REG_SET     = 3'd3;
  localparam logic [2:0] REG_CLR     = 3'd4;
  localparam logic [2:0] REG_RISE_EN = 3'd5;
  localparam logic [2:0] REG_FALL_EN = 3'd6;
  localparam logic [2:0] REG_STATUS  = 3'd7;

  typedef enum logic [2:0] {
    RegIn     = REG_IN,
    RegOut    = REG_OUT,
    RegOe     = REG_OE,
    RegSet    = REG_SET,
    RegClr    = REG_CLR,
    RegRiseEn = REG_RISE_EN,
    RegFallEn = REG_FALL_EN,
    RegStatus = REG_STATUS
  } gpio_reg_e;

  // Expand the four Wishbone byte selects into a 32-bit bit mask.
  function automatic logic [31:0] byte_mask(input logic [3:0] sel);
    logic [31:0] m;
    for (int i = 0; i < 4; i++) begin
      m[8*i +: 8] = {8{sel[i]}};
    end
    return m;
  endfunction

endpackage

// File: rtl/wb_gpio_ctrl_if.sv
// Wishbone pipelined bus bundle between the interconnect and the GPIO slave.
interface wb_gpio_ctrl_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              wb_cyc;
  logic              wb_stb;
  logic              wb_we;
  logic [ADDR_W-1:0] wb_adr;
  logic [3:0]        wb_sel;
  logic [31:0]       wb_dat_i;
  logic [31:0]       wb_dat_o;
  logic              wb_ack;
  logic              wb_stall;
  logic              wb_err;

  modport master (
    output wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
    input  wb_dat_o, wb_ack, wb_stall, wb_err
  );

  modport slave (
    input  wb_cyc, wb_stb, wb_we, wb_adr, wb_sel, wb_dat_i,
    output wb_dat_o, wb_ack, wb_stall, wb_err
  );
endinterface

// File: rtl/wb_gpio_ctrl_sync_edge.sv
// Two-flop synchroniser for the asynchronous pad inputs plus a delayed copy
// used to detect rising and falling edges of the synchronised value.
module gpio_sync_edge
  import wb_gpio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] pins,
  output logic [WIDTH-1:0] sync,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  logic [WIDTH-1:0] s1_q, s2_q, prev_q;

  // Synchroniser chain and one-cycle history of the synchronised value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
    end else begin
      s1_q   <= pins;
      s2_q   <= s1_q;
      prev_q <= s2_q;
    end
  end

  assign sync = s2_q;
  assign rise = s2_q & ~prev_q;
  assign fall = ~s2_q & prev_q;

endmodule

// File: rtl/wb_gpio_ctrl.sv
// Wishbone GPIO slave: pad output/enable registers, set/clear aliases,
// edge-capture status with write-1-to-clear and a level interrupt.
module wb_gpio_ctrl
  import wb_gpio_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH  = 16,
  parameter int unsigned ADDR_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_gpio_ctrl_if.slave    wb,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_n,
  output logic             irq
);

  logic             req, wr, rd;
  gpio_reg_e        reg_idx;
  logic [31:0]      wmask32;
  logic [WIDTH-1:0] wmask, wbits;
  logic [WIDTH-1:0] sync, rise, fall;
  logic [WIDTH-1:0] rdata;
  logic             unused_bits;

  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] oe_q, oe_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [31:0]      dat_q, dat_d;
  logic             ack_q;

  gpio_sync_edge #(
    .WIDTH (WIDTH)
  ) u_sync_edge (
    .clk   (clk),
    .rst_n (rst_n),
    .pins  (gpio_i),
    .sync  (sync),
    .rise  (rise),
    .fall  (fall)
  );

  assign req     = wb.wb_cyc & wb.wb_stb;
  assign wr      = req & wb.wb_we;
  assign rd      = req & ~wb.wb_we;
  assign reg_idx = gpio_reg_e'(wb.wb_adr[4:2]);
  assign wmask32 = byte_mask(wb.wb_sel);
  assign wmask   = wmask32[WIDTH-1:0];
  // Only the byte-lane-enabled write bits; used directly for SET/CLR/W1C.
  assign wbits   = wb.wb_dat_i[WIDTH-1:0] & wmask;

  // Address bits outside [4:2] and data/mask bits above WIDTH are don't-care.
  assign unused_bits = ^{wmask32, wb.wb_dat_i, wb.wb_adr[ADDR_W-1:5], wb.wb_adr[1:0]};

  // Register next-state: bus writes, then edge capture which overrides W1C.
  always_comb begin
    out_d     = out_q;
    oe_d      = oe_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    status_d  = status_q;
    if (wr) begin
      unique case (reg_idx)
        RegIn:     ;
        RegOut:    out_d     = (out_q & ~wmask) | wbits;
        RegOe:     oe_d      = (oe_q & ~wmask) | wbits;
        RegSet:    out_d     = out_q | wbits;
        RegClr:    out_d     = out_q & ~wbits;
        RegRiseEn: rise_en_d = (rise_en_q & ~wmask) | wbits;
        RegFallEn: fall_en_d = (fall_en_q & ~wmask) | wbits;
        RegStatus: status_d  = status_q & ~wbits;
        default:   ;
      endcase
    end
    status_d = status_d | (rise & rise_en_q) | (fall & fall_en_q);
  end

  // Read data mux, registered alongside the ack.
  always_comb begin
    rdata = '0;
    unique case (reg_idx)
      RegIn:          rdata = sync;
      RegOut:         rdata = out_q;
      RegOe:          rdata = oe_q;
      RegSet, RegClr: rdata = '0;
      RegRiseEn:      rdata = rise_en_q;
      RegFallEn:      rdata = fall_en_q;
      RegStatus:      rdata = status_q;
      default:        rdata = '0;
    endcase
    dat_d = '0;
    if (rd) begin
      dat_d[WIDTH-1:0] = rdata;
    end
  end

  // State registers and the one-cycle ack pipeline.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_q     <= '0;
      oe_q      <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      dat_q     <= '0;
      ack_q     <= 1'b0;
    end else begin
      out_q     <= out_d;
      oe_q      <= oe_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      dat_q     <= dat_d;
      ack_q     <= req;
    end
  end

  assign gpio_o      = out_q;
  assign gpio_oe_n   = ~oe_q;
  assign irq         = |status_q;
  assign wb.wb_ack   = ack_q;
  assign wb.wb_dat_o = dat_q;
  assign wb.wb_stall = 1'b0;
  assign wb.wb_err   = 1'b0;

endmodule

// File: tb/tb_wb_gpio_ctrl.sv
// Directed bench for wb_gpio_ctrl with a scoreboard of expected acks/read data.
module tb_wb_gpio_ctrl;
  import wb_gpio_ctrl_pkg::*;

  localparam int unsigned WIDTH = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [WIDTH-1:0] gpio_i;
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe_n;
  logic             irq;

  wb_gpio_ctrl_if #(.ADDR_W(32)) bus ();

  wb_gpio_ctrl #(
    .WIDTH  (WIDTH),
    .ADDR_W (32)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (bus),
    .gpio_i    (gpio_i),
    .gpio_o    (gpio_o),
    .gpio_oe_n (gpio_oe_n),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          due;
    bit          rd;
    logic [31:0] data;
    string       tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   cyc_cnt = 0;
  int   n_assert = 0;
  int   n_fail = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One bus request held for exactly one accepting edge; returns 1 time unit
  // after that edge. Back-to-back calls give back-to-back requests.
  task automatic req(input logic we, input logic [2:0] idx, input logic [3:0] sel,
                     input logic [31:0] dat, input logic [31:0] exp_rd, input string tag);
    exp_t e;
    @(negedge clk);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = we;
    bus.wb_adr   = {16'hA5A5, 11'd0, idx, 2'b00};
    bus.wb_sel   = sel;
    bus.wb_dat_i = dat;
    e.due  = cyc_cnt + 1;
    e.rd   = !we;
    e.data = exp_rd;
    e.tag  = tag;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
  endtask

  task automatic wr(input logic [2:0] idx, input logic [3:0] sel, input logic [31:0] dat,
                    input string tag);
    req(1'b1, idx, sel, dat, 32'd0, tag);
  endtask

  task automatic rd(input logic [2:0] idx, input logic [31:0] exp, input string tag);
    req(1'b0, idx, 4'hF, 32'd0, exp, tag);
  endtask

  // Ack monitor: every ack must match the oldest outstanding request, arrive in
  // the cycle after acceptance, and carry the expected read data.
  always begin
    @(posedge clk);
    cyc_cnt++;
    #1;
    if (bus.wb_ack) begin
      if (sb.size() == 0) begin
        check("ack_spurious", 32'(bus.wb_ack), 32'd0);
      end else begin
        mon_e = sb.pop_front();
        check({mon_e.tag, "_ack_cycle"}, 32'(cyc_cnt), 32'(mon_e.due));
        if (mon_e.rd) check(mon_e.tag, bus.wb_dat_o, mon_e.data);
      end
    end else if (sb.size() != 0 && sb[0].due <= cyc_cnt) begin
      check({sb[0].tag, "_ack_missing"}, 32'(bus.wb_ack), 32'd1);
      void'(sb.pop_front());
    end
  end

  initial begin
    rst_n        = 1'b0;
    gpio_i       = 16'hFFFF;
    bus.wb_cyc   = 1'b0;
    bus.wb_stb   = 1'b0;
    bus.wb_we    = 1'b0;
    bus.wb_adr   = '0;
    bus.wb_sel   = 4'h0;
    bus.wb_dat_i = '0;

    // Reset state with all pads high.
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe_n",  32'(gpio_oe_n), 32'h0000_FFFF);
    check("rst_gpio_o", 32'(gpio_o),   32'h0);
    check("rst_irq",   32'(irq),       32'h0);
    check("rst_ack",   32'(bus.wb_ack), 32'h0);
    check("rst_dat_o", bus.wb_dat_o,   32'h0);
    check("stall_err", {30'd0, bus.wb_stall, bus.wb_err}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    rd(REG_IN, 32'h0000_FFFF, "rd_in_after_rst");
    rd(REG_STATUS, 32'h0, "rd_status_after_rst");

    // Output enable and output value, each visible at the accepting edge.
    wr(REG_OE, 4'hF, 32'hABCD_00FF, "wr_oe");
    check("oe_n_after_wr", 32'(gpio_oe_n), 32'h0000_FF00);
    wr(REG_OUT, 4'hF, 32'h0000_1234, "wr_out");
    check("out_after_wr", 32'(gpio_o), 32'h0000_1234);
    wr(REG_SET, 4'hF, 32'h0000_8000, "wr_set");
    check("out_after_set", 32'(gpio_o), 32'h0000_9234);
    wr(REG_CLR, 4'hF, 32'h0000_0004, "wr_clr");
    check("out_after_clr", 32'(gpio_o), 32'h0000_9230);
    wr(REG_IN, 4'hF, 32'h0000_0000, "wr_in_ignored");
    rd(REG_IN, 32'h0000_FFFF, "rd_in_unchanged");

    // Back-to-back reads on consecutive cycles.
    rd(REG_OUT, 32'h0000_9230, "b2b_out");
    rd(REG_OE,  32'h0000_00FF, "b2b_oe");
    rd(REG_CLR, 32'h0, "b2b_clr");

    // Byte-lane gating on a plain write.
    wr(REG_OUT, 4'hF, 32'h0, "wr_out_zero");
    wr(REG_OUT, 4'b0010, 32'h0000_FFFF, "wr_out_lane1");
    check("out_lane1", 32'(gpio_o), 32'h0000_FF00);
    rd(REG_OUT, 32'h0000_FF00, "rd_out_lane1");

    // Rising-edge capture on pin 3; a falling edge first must set nothing.
    wr(REG_RISE_EN, 4'hF, 32'h0000_0008, "wr_rise_en");
    @(negedge clk);
    gpio_i = 16'hFFF7;
    repeat (4) @(posedge clk);
    #1;
    check("irq_fall_disabled", 32'(irq), 32'h0);
    rd(REG_STATUS, 32'h0, "status_fall_disabled");
    @(negedge clk);
    gpio_i = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    #1;
    check("irq_k1", 32'(irq), 32'h0);
    @(posedge clk);
    #1;
    check("irq_k2", 32'(irq), 32'h1);
    rd(REG_STATUS, 32'h0000_0008, "status_rise");
    wr(REG_STATUS, 4'b0010, 32'h0000_0008, "w1c_wrong_lane");
    check("irq_wrong_lane", 32'(irq), 32'h1);
    wr(REG_STATUS, 4'hF, 32'h0000_0008, "w1c");
    check("irq_after_w1c", 32'(irq), 32'h0);

    // Falling edge with only rise enabled leaves status clear.
    @(negedge clk);
    gpio_i = 16'hFFF7;
    repeat (4) @(posedge clk);
    #1;
    check("irq_after_fall", 32'(irq), 32'h0);
    rd(REG_STATUS, 32'h0, "status_after_fall");

    // Set a flag, then clear it in the very cycle a new rising edge is captured.
    @(negedge clk);
    gpio_i = 16'hFFFF;
    repeat (4) @(posedge clk);
    #1;
    check("irq_pre_collide", 32'(irq), 32'h1);
    @(negedge clk);
    gpio_i = 16'hFFF7;
    repeat (4) @(posedge clk);
    @(negedge clk);
    gpio_i = 16'hFFFF;
    @(posedge clk);
    @(posedge clk);
    wr(REG_STATUS, 4'hF, 32'h0000_0008, "w1c_collide");
    check("irq_collide", 32'(irq), 32'h1);
    rd(REG_STATUS, 32'h0000_0008, "status_collide");

    // Reset during an accepted write: reset wins and no ack follows.
    @(negedge clk);
    bus.wb_cyc   = 1'b1;
    bus.wb_stb   = 1'b1;
    bus.wb_we    = 1'b1;
    bus.wb_adr   = {27'd0, REG_OE, 2'b00};
    bus.wb_sel   = 4'hF;
    bus.wb_dat_i = 32'h0000_FFFF;
    rst_n        = 1'b0;
    @(posedge clk);
    #1;
    check("midrst_oe_n", 32'(gpio_oe_n), 32'h0000_FFFF);
    check("midrst_irq",  32'(irq),       32'h0);
    check("midrst_ack",  32'(bus.wb_ack), 32'h0);
    bus.wb_cyc = 1'b0;
    bus.wb_stb = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_no_ack", 32'(bus.wb_ack), 32'h0);
    rd(REG_OE, 32'h0, "rd_oe_after_midrst");

    repeat (3) @(posedge clk);
    #1;
    check("sb_drained", 32'(sb.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
